// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the RAM arbiter
//
// Purpose: FSM state encodings and port indices used by mem_arbiter and
// mem_arb_pick.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_ACK    = 2'd2
  } arb_state_t;

  localparam logic ARB_PORT_CPU = 1'b0;
  localparam logic ARB_PORT_AUX = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select for the RAM arbiter
//
// Purpose: choose which requesting port is granted in IDLE.
// Macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention;
//        undefined gives fixed port-0 priority.
// Ports:
//   req0, req1  in  request from port 0 / port 1
//   last_port   in  port served most recently (round-robin build only)
//   winner      out port to grant (meaningful only if a req is high)
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_port,
  output logic winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Contention goes to the port not served last; a lone request wins outright.
  assign winner = (req0 && req1) ? ~last_port
                                 : (req1 ? ARB_PORT_AUX : ARB_PORT_CPU);
`else
  logic unused_last_port;
  assign unused_last_port = last_port;
  assign winner = req0 ? ARB_PORT_CPU : (req1 ? ARB_PORT_AUX : ARB_PORT_CPU);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single-port sync RAM
//
// Purpose: grant one of two masters, latch its command, sequence the RAM
// read latency and return data with a one-cycle ack.
// Macro: MEM_ARB_ROUND_ROBIN_EN enables round-robin on contention.
// Ports:
//   clk, reset (async active-low)
//   pN_req/we/addr/wdata  in  master N command, req held until ack
//   pN_ack/rdata          out completion pulse and read data
//   ram_address/data/rden/wren out, ram_q in   RAM interface
//   busy   out  not IDLE
//   gnt_id out  port owning current or most recent transaction
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              gnt_id
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  arb_state_t        state;
  logic              cmd_port;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [LAT_W-1:0]  lat_cnt;
  logic              winner;
  logic              last_port;

  mem_arb_pick u_pick (
    .req0      (p0_req),
    .req1      (p1_req),
    .last_port (last_port),
    .winner    (winner)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_port <= ARB_PORT_AUX;
    end else if (state == ARB_ACK) begin
      last_port <= cmd_port;
    end
  end
`else
  assign last_port = ARB_PORT_AUX;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      cmd_port  <= ARB_PORT_CPU;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      lat_cnt   <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (p0_req || p1_req) begin
            cmd_port  <= winner;
            cmd_we    <= winner ? p1_we    : p0_we;
            cmd_addr  <= winner ? p1_addr  : p0_addr;
            cmd_wdata <= winner ? p1_wdata : p0_wdata;
            lat_cnt   <= '0;
            state     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cmd_we) begin
            state <= ARB_ACK;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
            // ram_q is valid at the edge closing the RD_LAT-th ACCESS cycle.
            if (lat_cnt == LAT_LAST) begin
              if (cmd_port == ARB_PORT_AUX) p1_rdata <= ram_q;
              else                          p0_rdata <= ram_q;
              state <= ARB_ACK;
            end
          end
        end
        ARB_ACK: state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // RAM and handshake outputs decode from state and latched command only,
  // so requests never reach the RAM combinationally.
  assign ram_address = (state == ARB_ACCESS) ? cmd_addr : '0;
  assign ram_data    = (state == ARB_ACCESS && cmd_we) ? cmd_wdata : '0;
  assign ram_wren    = (state == ARB_ACCESS) && cmd_we;
  assign ram_rden    = (state == ARB_ACCESS) && !cmd_we;
  assign p0_ack      = (state == ARB_ACK) && (cmd_port == ARB_PORT_CPU);
  assign p1_ack      = (state == ARB_ACK) && (cmd_port == ARB_PORT_AUX);
  assign busy        = (state != ARB_IDLE);
  assign gnt_id      = cmd_port;

endmodule
